// File: rtl/csr_pulsegen.sv
// CSR-bus pulse-train generator: programmable high/low widths and pulse count,
// single registered pulse output, one-cycle completion irq and sticky DONE flag.
module csr_pulsegen #(
  parameter logic [3:0]  csr_addr  = 4'h2,
  parameter int unsigned cnt_width = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic        pulse_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_HIGH   = 3'd1;
  localparam logic [2:0] A_LOW    = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_REMAIN = 3'd4;
  localparam logic [2:0] A_DONE   = 3'd5;

  localparam logic [cnt_width-1:0] ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [cnt_width-1:0] remain_q, remain_d;
  logic [cnt_width-1:0] high_q, low_q, count_q;
  logic [cnt_width-1:0] high_eff, low_eff;
  logic                 cont_q;
  logic                 done_q;
  logic                 irq_d;
  logic                 busy;
  logic                 sel;
  logic                 wr_ctrl, wr_high, wr_low, wr_count, wr_done;
  logic                 start_req, abort_req;
  logic [31:0]          rd_data;

  assign sel      = (csr_a[13:10] == csr_addr);
  assign wr_ctrl  = sel && csr_we && (csr_a[2:0] == A_CTRL);
  assign wr_high  = sel && csr_we && (csr_a[2:0] == A_HIGH);
  assign wr_low   = sel && csr_we && (csr_a[2:0] == A_LOW);
  assign wr_count = sel && csr_we && (csr_a[2:0] == A_COUNT);
  assign wr_done  = sel && csr_we && (csr_a[2:0] == A_DONE);

  assign abort_req = wr_ctrl && csr_di[2];
  assign start_req = wr_ctrl && csr_di[0] && !csr_di[2];

  assign high_eff = (high_q == '0) ? ONE : high_q;
  assign low_eff  = (low_q  == '0) ? ONE : low_q;
  assign busy     = (state_q != S_IDLE);

  // Phase counter holds cycles left in the current phase after this one,
  // so a width of w loads w-1 and the phase ends when it reads zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    irq_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req && (csr_di[1] || (count_q != '0))) begin
          state_d  = S_HIGH;
          cnt_d    = high_eff - ONE;
          remain_d = count_q;
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (cont_q) begin
          state_d = S_LOW;
          cnt_d   = low_eff - ONE;
        end else if (remain_q <= ONE) begin
          state_d  = S_IDLE;
          remain_d = '0;
          irq_d    = 1'b1;
        end else begin
          state_d  = S_LOW;
          remain_d = remain_q - ONE;
          cnt_d    = low_eff - ONE;
        end
      end
      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = S_HIGH;
          cnt_d   = high_eff - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_req && busy) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      remain_d = '0;
      irq_d    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      remain_q <= '0;
      irq      <= 1'b0;
      pulse_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      irq      <= irq_d;
      pulse_o  <= (state_d == S_HIGH);
    end
  end

  always_comb begin
    rd_data = '0;
    case (csr_a[2:0])
      A_CTRL:   rd_data = {30'd0, cont_q, busy};
      A_HIGH:   rd_data = 32'(high_q);
      A_LOW:    rd_data = 32'(low_q);
      A_COUNT:  rd_data = 32'(count_q);
      A_REMAIN: rd_data = 32'(remain_q);
      A_DONE:   rd_data = {31'd0, done_q};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      high_q  <= '0;
      low_q   <= '0;
      count_q <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
      csr_do  <= '0;
    end else begin
      if (wr_high)  high_q  <= csr_di[cnt_width-1:0];
      if (wr_low)   low_q   <= csr_di[cnt_width-1:0];
      if (wr_count) count_q <= csr_di[cnt_width-1:0];
      if (wr_ctrl)  cont_q  <= csr_di[1];
      // Completion in the same cycle as a DONE write leaves the flag set.
      if (irq_d)        done_q <= 1'b1;
      else if (wr_done) done_q <= 1'b0;
      csr_do <= sel ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_csr_pulsegen.sv
// Directed and randomized bench for csr_pulsegen; expected waveforms are built
// as per-cycle queues from the programmed widths and count.
module tb_csr_pulsegen;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        irq;
  logic        pulse_o;

  csr_pulsegen #(.csr_addr(4'h2), .cnt_width(32)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .csr_a    (csr_a),
    .csr_we   (csr_we),
    .csr_di   (csr_di),
    .csr_do   (csr_do),
    .irq      (irq),
    .pulse_o  (pulse_o)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [2:0] R_CTRL = 3'd0, R_HIGH = 3'd1, R_LOW = 3'd2;
  localparam logic [2:0] R_COUNT = 3'd3, R_REMAIN = 3'd4, R_DONE = 3'd5;
  localparam logic [31:0] START = 32'd1, CONT = 32'd2, ABORT = 32'd4;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          exp_p[$];
  int unsigned exp_r[$];

  function automatic logic [13:0] ad(input logic [2:0] r, input logic [3:0] pg = 4'h2);
    return {pg, 7'd0, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    csr_a  = a;
    csr_we = 1'b0;
    tick();
    d = csr_do;
  endtask

  // Pulse i (0-based) of c: high width cycles with c-i pulses outstanding,
  // then (except after the last) low width cycles with c-i-1 outstanding.
  task automatic build(input int unsigned h, input int unsigned l, input int unsigned c);
    int unsigned he, le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    exp_p.delete();
    exp_r.delete();
    for (int unsigned i = 0; i < c; i++) begin
      for (int unsigned j = 0; j < he; j++) begin exp_p.push_back(1'b1); exp_r.push_back(c - i); end
      if (i < c - 1)
        for (int unsigned j = 0; j < le; j++) begin exp_p.push_back(1'b0); exp_r.push_back(c - i - 1); end
    end
  endtask

  task automatic follow(input int unsigned from, input bit chk_rem);
    logic [31:0] d;
    if (chk_rem) csr_a = ad(R_REMAIN);
    for (int unsigned k = from; k < exp_p.size(); k++) begin
      check("pulse", {31'd0, pulse_o}, {31'd0, exp_p[k]});
      check("irq_early", {31'd0, irq}, 32'd0);
      if (chk_rem && k > from) check("remain", csr_do, exp_r[k-1]);
      tick();
    end
    check("pulse_end", {31'd0, pulse_o}, 32'd0);
    check("irq_done", {31'd0, irq}, 32'd1);
    if (chk_rem) check("remain_last", csr_do, exp_r[exp_p.size()-1]);
    tick();
    check("irq_once", {31'd0, irq}, 32'd0);
    if (chk_rem) check("remain_zero", csr_do, 32'd0);
    csr_read(ad(R_DONE), d);
    check("done_flag", d, 32'd1);
    csr_read(ad(R_CTRL), d);
    check("busy_clear", d & 32'd1, 32'd0);
    csr_write(ad(R_DONE), 32'd0);
  endtask

  task automatic run_train(input int unsigned h, input int unsigned l, input int unsigned c, input bit chk_rem);
    csr_write(ad(R_HIGH), h);
    csr_write(ad(R_LOW), l);
    csr_write(ad(R_COUNT), c);
    build(h, l, c);
    csr_write(ad(R_CTRL), START);
    follow(0, chk_rem);
  endtask

  initial begin
    logic [31:0] d;
    int unsigned npulse;
    int unsigned h, l, c;

    // Reset state
    tick();
    tick();
    check("rst_pulse", {31'd0, pulse_o}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_do", csr_do, 32'd0);
    sys_rst_n = 1'b1;
    for (int unsigned r = 0; r < 8; r++) begin
      csr_read(ad(3'(r)), d);
      check("rst_reg", d, 32'd0);
    end

    // Register readback and page decode
    csr_write(ad(R_HIGH), 32'd7);
    csr_write(ad(R_LOW), 32'd9);
    csr_write(ad(R_HIGH, 4'h3), 32'd55);
    csr_write(ad(R_REMAIN), 32'd12);
    csr_read(ad(R_HIGH), d);  check("rd_high", d, 32'd7);
    csr_read(ad(R_LOW), d);   check("rd_low", d, 32'd9);
    csr_read(ad(R_REMAIN), d); check("rd_remain_ro", d, 32'd0);
    csr_read(ad(R_HIGH, 4'h3), d); check("other_page", d, 32'd0);

    // Directed trains
    run_train(3, 2, 2, 1'b1);
    run_train(0, 0, 4, 1'b1);

    // Randomized trains
    for (int unsigned t = 0; t < 6; t++) begin
      h = $urandom_range(0, 5);
      l = $urandom_range(0, 5);
      c = $urandom_range(1, 4);
      run_train(h, l, c, 1'b1);
    end

    // HIGH rewritten during the first high phase applies to the second pulse
    csr_write(ad(R_HIGH), 32'd2);
    csr_write(ad(R_LOW), 32'd1);
    csr_write(ad(R_COUNT), 32'd2);
    exp_p = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    csr_write(ad(R_CTRL), START);
    check("hw_pulse0", {31'd0, pulse_o}, 32'd1);
    csr_write(ad(R_HIGH), 32'd5);
    follow(1, 1'b0);

    // START and COUNT while busy leave the running train alone
    csr_write(ad(R_HIGH), 32'd2);
    csr_write(ad(R_COUNT), 32'd3);
    build(2, 1, 3);
    csr_write(ad(R_CTRL), START);
    check("busy_p0", {31'd0, pulse_o}, {31'd0, exp_p[0]});
    csr_write(ad(R_COUNT), 32'd1);
    check("busy_p1", {31'd0, pulse_o}, {31'd0, exp_p[1]});
    csr_write(ad(R_CTRL), START);
    follow(2, 1'b0);
    build(2, 1, 1);
    csr_write(ad(R_CTRL), START);
    follow(0, 1'b0);

    // DONE write in the completion cycle: set wins
    csr_write(ad(R_HIGH), 32'd3);
    csr_write(ad(R_COUNT), 32'd1);
    csr_write(ad(R_CTRL), START);
    tick();
    tick();
    csr_write(ad(R_DONE), 32'd0);
    check("coinc_irq", {31'd0, irq}, 32'd1);
    csr_read(ad(R_DONE), d);
    check("coinc_done", d, 32'd1);
    csr_write(ad(R_DONE), 32'd0);
    csr_read(ad(R_DONE), d);
    check("done_clear", d, 32'd0);

    // START with COUNT=0 and CONT=0 is ignored
    csr_write(ad(R_COUNT), 32'd0);
    csr_write(ad(R_CTRL), START);
    for (int unsigned k = 0; k < 3; k++) begin
      check("cnt0_pulse", {31'd0, pulse_o}, 32'd0);
      check("cnt0_irq", {31'd0, irq}, 32'd0);
      tick();
    end
    csr_read(ad(R_CTRL), d);
    check("cnt0_busy", d, 32'd0);

    // Free-running widths of 1 for 100 cycles, then ABORT
    csr_write(ad(R_HIGH), 32'd1);
    csr_write(ad(R_LOW), 32'd1);
    csr_write(ad(R_CTRL), START | CONT);
    csr_a = ad(R_CTRL);
    npulse = 0;
    for (int unsigned k = 0; k < 99; k++) begin
      if (pulse_o) npulse++;
      check("cont_irq", {31'd0, irq}, 32'd0);
      tick();
    end
    check("cont_status", csr_do, 32'd3);
    if (pulse_o) npulse++;
    csr_write(ad(R_CTRL), ABORT);
    check("cont_npulse", npulse, 32'd50);
    check("abort_pulse", {31'd0, pulse_o}, 32'd0);
    check("abort_irq", {31'd0, irq}, 32'd0);
    tick();
    check("abort_irq2", {31'd0, irq}, 32'd0);
    csr_read(ad(R_REMAIN), d); check("abort_remain", d, 32'd0);
    csr_read(ad(R_CTRL), d);   check("abort_busy", d, 32'd0);
    csr_read(ad(R_DONE), d);   check("abort_done", d, 32'd0);

    // ABORT while idle has no effect; a later train still works
    csr_write(ad(R_CTRL), ABORT);
    run_train(1, 2, 2, 1'b1);

    // Asynchronous reset mid-train
    csr_write(ad(R_HIGH), 32'd10);
    csr_write(ad(R_COUNT), 32'd3);
    csr_write(ad(R_CTRL), START);
    tick();
    tick();
    check("pre_rst_pulse", {31'd0, pulse_o}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_pulse", {31'd0, pulse_o}, 32'd0);
    check("arst_do", csr_do, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    csr_read(ad(R_HIGH), d); check("arst_high", d, 32'd0);
    csr_read(ad(R_CTRL), d); check("arst_ctrl", d, 32'd0);
    check("arst_pulse2", {31'd0, pulse_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
